// File: rtl/pwm_multi_ch.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : pwm_multi_ch                                               |
// | Description : N-channel PWM generator, edge/center aligned, with         |
// |               double-buffered duty values applied at period boundaries.  |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+

module pwm_multi_ch #(
    parameter int              CH  = 3,
    parameter int              W   = 8,
    parameter logic [CH-1:0]   POL = '0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              en,
    input  logic              tick,
    input  logic              mode,
    input  logic              duty_wr,
    input  logic [CH*W-1:0]   duty_in,
    output logic [CH-1:0]     pwm,
    output logic              period_start,
    output logic              load_pending
);

    localparam logic [W-1:0] c_MAX  = '1;
    localparam logic         c_UP   = 1'b0;
    localparam logic         c_DOWN = 1'b1;

    logic [W-1:0]    ctr_q,    ctr_d;
    logic            dir_q,    dir_d;
    logic            mode_q,   mode_d;
    logic [CH*W-1:0] shadow_q, shadow_d;
    logic [CH*W-1:0] active_q, active_d;
    logic            pend_q,   pend_d;
    logic            pstart_q, pstart_d;
    logic [CH-1:0]   pwm_q,    pwm_d;

    logic [W-1:0]    ctr_step;
    logic            dir_step;
    logic            boundary;
    logic            load;
    logic [CH-1:0]   raw;

    // Counter value and direction one tick ahead, independent of en/tick.
    always_comb begin
        ctr_step = ctr_q;
        dir_step = dir_q;
        if (!mode_q) begin
            ctr_step = ctr_q + 1'b1;
            dir_step = c_UP;
        end else if (dir_q == c_UP) begin
            ctr_step = ctr_q + 1'b1;
            dir_step = (ctr_step == c_MAX) ? c_DOWN : c_UP;
        end else begin
            ctr_step = ctr_q - 1'b1;
            dir_step = (ctr_step == '0) ? c_UP : c_DOWN;
        end
    end

    assign boundary = en && tick && (ctr_step == '0);
    // Parking the counter (en low) is also a safe point to apply a pending load.
    assign load     = pend_q && (boundary || !en);

    for (genvar i = 0; i < CH; i++) begin : g_ch
        assign raw[i] = (ctr_q < active_q[i*W +: W]);
    end

    always_comb begin
        ctr_d    = ctr_q;
        dir_d    = dir_q;
        mode_d   = mode_q;
        shadow_d = shadow_q;
        active_d = active_q;
        pend_d   = pend_q;
        pstart_d = 1'b0;
        pwm_d    = POL;

        if (!en) begin
            ctr_d  = '0;
            dir_d  = c_UP;
            mode_d = mode;
        end else begin
            pwm_d = raw ^ POL;
            if (tick) begin
                ctr_d = ctr_step;
                dir_d = dir_step;
            end
            if (boundary) begin
                dir_d    = c_UP;
                mode_d   = mode;
                pstart_d = 1'b1;
            end
        end

        // A write on the load edge wins the shadow but the old shadow still lands.
        if (load) begin
            active_d = shadow_q;
            pend_d   = 1'b0;
        end
        if (duty_wr) begin
            shadow_d = duty_in;
            pend_d   = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ctr_q    <= '0;
            dir_q    <= c_UP;
            mode_q   <= 1'b0;
            shadow_q <= '0;
            active_q <= '0;
            pend_q   <= 1'b0;
            pstart_q <= 1'b0;
            pwm_q    <= POL;
        end else begin
            ctr_q    <= ctr_d;
            dir_q    <= dir_d;
            mode_q   <= mode_d;
            shadow_q <= shadow_d;
            active_q <= active_d;
            pend_q   <= pend_d;
            pstart_q <= pstart_d;
            pwm_q    <= pwm_d;
        end
    end

    assign pwm          = pwm_q;
    assign period_start = pstart_q;
    assign load_pending = pend_q;

endmodule

`default_nettype wire
